// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Purpose  : Sequences one run of an attached core:
//            IDLE -> HOLD (core held in reset) -> RUN (wait for every
//            completion channel, or give up at a cycle budget) -> DRAIN
//            (settle) -> DONE. A run that exhausts its budget goes to
//            TIMEOUT instead. Result words are captured on the final
//            DRAIN cycle.
// Ports    : clk          - sole clock, rising edge
//            reset        - synchronous, active-low
//            start        - run request (honoured in IDLE/DONE/TIMEOUT only)
//            done_in      - per-channel completion from the core
//            result0/1    - core result words
//            core_reset   - active-high reset driven to the core
//            running      - high in RUN and DRAIN
//            finished     - high in DONE
//            timed_out    - high in TIMEOUT
//            done_mask    - sticky per-channel completion flags
//            cycle_count  - RUN+DRAIN cycles of the current/last run
//                           (saturating)
//            cap_result0/1- results captured at the end of DRAIN
// Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int NUM_CH         = 1,
    parameter int DATA_W         = 32,
    parameter int RESET_CYCLES   = 10,
    parameter int DRAIN_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] done_in,
    input  logic [DATA_W-1:0] result0,
    input  logic [DATA_W-1:0] result1,
    output logic              core_reset,
    output logic              running,
    output logic              finished,
    output logic              timed_out,
    output logic [NUM_CH-1:0] done_mask,
    output logic [31:0]       cycle_count,
    output logic [DATA_W-1:0] cap_result0,
    output logic [DATA_W-1:0] cap_result1
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    // Terminal counter values. A zero-length drain still spends one cycle
    // in DRAIN so the capture always happens on a DRAIN cycle.
    localparam logic [31:0] c_HOLD_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] c_DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0
                                                               : 32'(DRAIN_CYCLES - 1);
    localparam logic [31:0] c_TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_drain_cnt;
    logic        w_all_done;
    logic [31:0] w_count_inc;

    // Completion looks at this cycle's done_in too, so a channel finishing
    // on the last budget cycle still counts.
    assign w_all_done  = &(done_mask | done_in);
    assign w_count_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count
                                                        : cycle_count + 32'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_HOLD;
            ST_HOLD:    if (r_hold_cnt == c_HOLD_LAST) w_next = ST_RUN;
            ST_RUN: begin
                if (w_all_done)                     w_next = ST_DRAIN;
                else if (cycle_count >= c_TO_LAST)  w_next = ST_TIMEOUT;
            end
            ST_DRAIN:   if (r_drain_cnt == c_DRAIN_LAST) w_next = ST_DONE;
            ST_DONE:    if (start) w_next = ST_HOLD;
            ST_TIMEOUT: if (start) w_next = ST_HOLD;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= 32'd0;
            r_drain_cnt <= 32'd0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
            done_mask   <= '0;
            cycle_count <= 32'd0;
            cap_result0 <= '0;
            cap_result1 <= '0;
        end else begin
            r_state <= w_next;

            // Status outputs are registered from the next state so they
            // line up with the state register.
            core_reset <= (w_next == ST_IDLE) || (w_next == ST_HOLD) ||
                          (w_next == ST_TIMEOUT);
            running    <= (w_next == ST_RUN) || (w_next == ST_DRAIN);
            finished   <= (w_next == ST_DONE);
            timed_out  <= (w_next == ST_TIMEOUT);

            case (r_state)
                ST_IDLE: begin
                    done_mask   <= '0;
                    cycle_count <= 32'd0;
                    r_hold_cnt  <= 32'd0;
                end
                ST_HOLD: begin
                    r_hold_cnt  <= r_hold_cnt + 32'd1;
                    r_drain_cnt <= 32'd0;
                end
                ST_RUN: begin
                    cycle_count <= w_count_inc;
                    done_mask   <= done_mask | done_in;
                end
                ST_DRAIN: begin
                    cycle_count <= w_count_inc;
                    r_drain_cnt <= r_drain_cnt + 32'd1;
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        cap_result0 <= result0;
                        cap_result1 <= result1;
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    // Captures survive a restart until the next DRAIN.
                    if (start) begin
                        done_mask   <= '0;
                        cycle_count <= 32'd0;
                        r_hold_cnt  <= 32'd0;
                    end
                end
                default: begin
                    r_hold_cnt <= 32'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of completion channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: width of result inputs and captures.
REQ-003 SHALL have parameter RESET_CYCLES, default 10: core-reset hold length in cycles (>=1).
REQ-004 SHALL have parameter DRAIN_CYCLES, default 10: post-completion settle cycles before capture (>=0).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100: run-phase cycle budget (>=2).
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  one clock; reset is synchronous and active-low.
REQ-008 SHALL have port start  input  1  request a run; sampled in IDLE, DONE, TIMEOUT only.
REQ-009 SHALL have port done_in  input  NUM_CH  per-channel completion pulse or level from the core.
REQ-010 SHALL have port result0  input  DATA_W  core result word 0.
REQ-011 SHALL have port result1  input  DATA_W  core result word 1.
REQ-012 SHALL have port core_reset  output  1  active-high reset driven to the core.
REQ-013 SHALL have port running  output  1  high in RUN and DRAIN.
REQ-014 SHALL have port finished  output  1  high in DONE.
REQ-015 SHALL have port timed_out  output  1  high in TIMEOUT.
REQ-016 SHALL have port done_mask  output  NUM_CH  sticky per-channel completion flags.
REQ-017 SHALL have port cycle_count  output  32  cycles spent in RUN plus DRAIN for the current/last run.
REQ-018 SHALL have ports cap_result0, cap_result1  output  DATA_W  results captured at end of DRAIN.

Function
REQ-019 SHALL implement states IDLE, HOLD, RUN, DRAIN, DONE, TIMEOUT; all outputs registered.
REQ-020 SHALL, in IDLE, drive core_reset=1; start=1 -> HOLD; clears done_mask, cycle_count, hold counter.
REQ-021 SHALL, in HOLD, keep core_reset=1 for exactly RESET_CYCLES cycles, then -> RUN (core_reset=0 from first RUN cycle).
REQ-022 SHALL, in RUN, increment cycle_count each cycle and OR done_in into done_mask.
REQ-023 SHALL leave RUN for DRAIN on the cycle where (done_mask | done_in) is all ones.
REQ-024 SHALL leave RUN for TIMEOUT when cycle_count reaches TIMEOUT_CYCLES-1 and completion (REQ-023) is not met that cycle; completion wins on a same-cycle tie.
REQ-025 SHALL, in DRAIN, keep core_reset=0, increment cycle_count, count DRAIN_CYCLES cycles; DRAIN_CYCLES=0 passes through DRAIN in one cycle.
REQ-026 SHALL, on the last DRAIN cycle, capture result0/result1 into cap_result0/cap_result1 and -> DONE.
REQ-027 SHALL, in DONE, hold core_reset=0, captures and cycle_count stable; start=1 -> HOLD.
REQ-028 SHALL, in TIMEOUT, drive core_reset=1, leave captures unchanged from the prior run; start=1 -> HOLD.
REQ-029 SHALL ignore start in HOLD, RUN, DRAIN; done_in ignored outside RUN.
REQ-030 SHALL saturate cycle_count at 32'hFFFF_FFFF (no wrap).
REQ-031 SHALL, on re-entry to HOLD from DONE/TIMEOUT, clear done_mask and cycle_count but preserve cap_result0/1 until next capture.

Reset
REQ-032 SHALL, with reset=0 at a rising edge, force state IDLE, core_reset=1, running=0, finished=0, timed_out=0, done_mask=0, cycle_count=0, cap_result0/1=0.
REQ-033 SHALL honour reset in any state including mid-HOLD, mid-RUN, mid-DRAIN; takes priority over start and done_in.

Verification (NUM_CH=2, RESET_CYCLES=4, DRAIN_CYCLES=3, TIMEOUT_CYCLES=20)
REQ-034 SHALL cover: reset low 3 cycles -> all outputs at REQ-032 values; start pulse -> core_reset high exactly 4 cycles then low.
REQ-035 SHALL cover: done_in=01 at RUN cycle 5, 10 at cycle 9, result0=32'h0000_002A, result1=32'h0000_0007 -> DRAIN 3 cycles, finished=1, cap_result0=2A, cap_result1=7, cycle_count=12.
REQ-036 SHALL cover: only done_in=01 asserted -> timed_out=1 after 20 RUN cycles, core_reset=1, done_mask=01, cycle_count=20.
REQ-037 SHALL cover: done_in=11 on RUN cycle 20 (timeout cycle) -> DRAIN, not TIMEOUT.
REQ-038 SHALL cover: reset low during DRAIN -> IDLE next cycle, captures=0; start during RUN ignored (no restart).
REQ-039 SHALL cover: start in DONE -> HOLD, done_mask=00, cycle_count=0, cap_result0 still 2A until next capture.
